ntt_stage_sequencer: RTL and testbench

- Control FSM that drives one complete NTT on the core array.
- Steps the router stage controls (log_m, log_t) through every butterfly stage, then through the final output pass where log_t = 15 (the 4-bit encoding of -1).
- For each stage, streams read/write word addresses to the core RAMs and the router, and inserts drain gaps so loop write-back completes before the next stage reads.
- Provides start/busy/done handshake to the top level and an out_valid strobe aligned with router output data.

---
 rtl/ntt_stage_sequencer_if.sv | 24 ++
 rtl/ntt_stage_sequencer.sv | 154 +++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_sequencer_if.sv
// rtl/ntt_stage_sequencer_if.sv - control and address bus between the NTT sequencer and the core array
interface ntt_stage_sequencer_if;
    logic       start;
    logic       out_ready;
    logic [3:0] log_m;
    logic [3:0] log_t;
    logic [8:0] address_0;
    logic [8:0] address_1;
    logic       issue_valid;
    logic [1:0] phase;
    logic       out_valid;
    logic       busy;
    logic       done;

    modport master (
        input  start, out_ready,
        output log_m, log_t, address_0, address_1, issue_valid, phase, out_valid, busy, done
    );

    modport slave (
        output start, out_ready,
        input  log_m, log_t, address_0, address_1, issue_valid, phase, out_valid, busy, done
    );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// rtl/ntt_stage_sequencer.sv - stage/address sequencer that walks one full NTT through the core array
module ntt_stage_sequencer #(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 5,
    parameter int DRAIN_CYCLES   = 4,
    parameter int READ_LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ntt_stage_sequencer_if.master bus
);
    localparam int WORDS = 1 << (LOG_N - LOG_CORE_COUNT - 2);
    localparam int CW    = $clog2(WORDS) + 1;
    localparam int DW    = $clog2(DRAIN_CYCLES) + 1;
    localparam int SW    = 5;
    localparam int PIPE  = READ_LATENCY + 1;

    localparam logic [8:0]    BANK1      = 9'(WORDS);
    localparam logic [8:0]    OUT_BASE   = (LOG_N % 2 == 1) ? 9'd0 : BANK1;
    localparam logic [3:0]    LOG_T_TOP  = 4'(LOG_N - 1);
    localparam logic [3:0]    PHASE_EDGE = 4'(LOG_N - (LOG_CORE_COUNT + 2));
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(WORDS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES - 1);

    if (2 * WORDS > 512) begin : g_words_check
        $error("ntt_stage_sequencer: 2*WORDS exceeds the 9-bit address space");
    end
    if (DRAIN_CYCLES < 1 || READ_LATENCY < 1) begin : g_param_check
        $error("ntt_stage_sequencer: DRAIN_CYCLES and READ_LATENCY must be >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUTPUT, S_FLUSH, S_DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   stage_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   drain_q;
    logic [3:0]      log_m_q;
    logic [3:0]      log_t_q;
    logic [8:0]      addr_q;
    logic            issue_q;
    logic            out_issue_q;
    logic [PIPE-1:0] pipe_q;
    logic [1:0]      phase_q;
    logic            busy_q;
    logic            done_q;

    // Converge stages span more than one core, pairwise stages stay within a core.
    function automatic logic [1:0] run_phase(input logic [3:0] lt);
        return (lt > PHASE_EDGE) ? 2'd0 : 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            log_m_q     <= '0;
            log_t_q     <= LOG_T_TOP;
            addr_q      <= '0;
            issue_q     <= 1'b0;
            out_issue_q <= 1'b0;
            pipe_q      <= '0;
            phase_q     <= 2'd3;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pipe_q      <= {pipe_q[PIPE-2:0], out_issue_q};
            issue_q     <= 1'b0;
            out_issue_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        stage_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        phase_q <= run_phase(LOG_T_TOP);
                    end
                end
                S_RUN: begin
                    issue_q <= 1'b1;
                    addr_q  <= (stage_q[0] ? BANK1 : 9'd0) + 9'(cnt_q);
                    log_m_q <= 4'(stage_q);
                    log_t_q <= LOG_T_TOP - 4'(stage_q);
                    phase_q <= run_phase(LOG_T_TOP - 4'(stage_q));
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == LAST_DRAIN) begin
                        if (stage_q == LAST_STAGE) begin
                            state_q <= S_OUTPUT;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            state_q <= S_RUN;
                        end
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    // While stalled the address shows the pending word so it resumes in place.
                    log_m_q <= 4'(LOG_N);
                    log_t_q <= 4'hF;
                    phase_q <= 2'd2;
                    addr_q  <= OUT_BASE + 9'(cnt_q);
                    if (bus.out_ready) begin
                        issue_q     <= 1'b1;
                        out_issue_q <= 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= S_FLUSH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!out_issue_q && pipe_q[PIPE-2:0] == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        phase_q <= 2'd3;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.log_m       = log_m_q;
    assign bus.log_t       = log_t_q;
    assign bus.address_0   = addr_q;
    assign bus.address_1   = addr_q;
    assign bus.issue_valid = issue_q;
    assign bus.phase       = phase_q;
    assign bus.out_valid   = pipe_q[PIPE-1];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb/tb_ntt_stage_sequencer.sv - directed bench for ntt_stage_sequencer at defaults and a swept configuration
module tb_ntt_stage_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b1;

    int n_checks = 0;
    int n_pass = 0;

    ntt_stage_sequencer_if bus_a ();
    ntt_stage_sequencer_if bus_b ();

    assign bus_a.start     = start;
    assign bus_a.out_ready = out_ready;
    assign bus_b.start     = start;
    assign bus_b.out_ready = out_ready;

    ntt_stage_sequencer #(.LOG_N(12), .LOG_CORE_COUNT(5), .DRAIN_CYCLES(4), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    ntt_stage_sequencer #(.LOG_N(12), .LOG_CORE_COUNT(4), .DRAIN_CYCLES(1), .READ_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    logic       a_iv [0:1023];
    logic       a_ov [0:1023];
    logic       a_dn [0:1023];
    logic       a_bz [0:1023];
    logic [8:0] a_a0 [0:1023];
    logic [8:0] a_a1 [0:1023];
    logic [3:0] a_lm [0:1023];
    logic [3:0] a_lt [0:1023];
    logic [1:0] a_ph [0:1023];
    logic       b_iv [0:1023];
    logic [8:0] b_a0 [0:1023];
    logic [3:0] b_lt [0:1023];
    logic [1:0] b_ph [0:1023];
    int a_done, b_done, last_cyc;

    // Cycle 0 is the edge that samples start; every later cycle is sampled 1 time unit after its edge.
    task automatic run(input int stall_from, input int stall_len, input int extra_start, input int rst_at);
        for (int i = 0; i < 1024; i++) begin
            a_iv[i] = 0; a_ov[i] = 0; a_dn[i] = 0; a_bz[i] = 0;
            a_a0[i] = 0; a_a1[i] = 0; a_lm[i] = 0; a_lt[i] = 0; a_ph[i] = 0;
            b_iv[i] = 0; b_a0[i] = 0; b_lt[i] = 0; b_ph[i] = 0;
        end
        a_done = -1; b_done = -1; last_cyc = 0;
        out_ready = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (c > 0) begin
                start     = (c == extra_start);
                rst       = (c == rst_at);
                out_ready = !(c >= stall_from && c < stall_from + stall_len);
            end
            @(posedge clk);
            #1;
            a_iv[c] = bus_a.issue_valid; a_ov[c] = bus_a.out_valid; a_dn[c] = bus_a.done;
            a_bz[c] = bus_a.busy; a_a0[c] = bus_a.address_0; a_a1[c] = bus_a.address_1;
            a_lm[c] = bus_a.log_m; a_lt[c] = bus_a.log_t; a_ph[c] = bus_a.phase;
            b_iv[c] = bus_b.issue_valid; b_a0[c] = bus_b.address_0;
            b_lt[c] = bus_b.log_t; b_ph[c] = bus_b.phase;
            if (bus_a.done && a_done < 0) a_done = c;
            if (bus_b.done && b_done < 0) b_done = c;
            last_cyc = c;
            if (rst_at >= 0 && c >= rst_at + 5) break;
            if (rst_at < 0 && a_done >= 0 && b_done >= 0 && c >= a_done + 3 && c >= b_done + 3) break;
        end
        start = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.log_m !== 4'd0 || bus_a.log_t !== 4'd11) $display("FAIL reset_log: got m=%0d t=%0d want m=0 t=11", bus_a.log_m, bus_a.log_t);
        else n_pass++;
        n_checks++;
        if (bus_a.address_0 !== 9'd0 || bus_a.address_1 !== 9'd0) $display("FAIL reset_addr: got %0d/%0d want 0/0", bus_a.address_0, bus_a.address_1);
        else n_pass++;
        n_checks++;
        if (bus_a.issue_valid !== 1'b0 || bus_a.out_valid !== 1'b0) $display("FAIL reset_valid: got iv=%0b ov=%0b want 0/0", bus_a.issue_valid, bus_a.out_valid);
        else n_pass++;
        n_checks++;
        if (bus_a.phase !== 2'd3) $display("FAIL reset_phase: got %0d want 3", bus_a.phase);
        else n_pass++;
        n_checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_b.busy !== 1'b0) $display("FAIL reset_busy_done: got busy=%0b done=%0b want 0/0", bus_a.busy, bus_a.done);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        int niv, nov;
        run(-1, 0, -1, -1);
        n_checks++;
        if (a_done !== 467) $display("FAIL nominal_done_cycle: got %0d want 467", a_done);
        else n_pass++;
        n_checks++;
        if (a_iv[0] !== 1'b0 || a_iv[1] !== 1'b1) $display("FAIL first_issue: got iv0=%0b iv1=%0b want 0/1", a_iv[0], a_iv[1]);
        else n_pass++;
        n_checks++;
        if (a_a0[1] !== 9'd0 || a_lm[1] !== 4'd0 || a_lt[1] !== 4'd11 || a_ph[1] !== 2'd0)
            $display("FAIL first_issue_fields: got a=%0d m=%0d t=%0d ph=%0d want 0/0/11/0", a_a0[1], a_lm[1], a_lt[1], a_ph[1]);
        else n_pass++;
        niv = 0; nov = 0;
        for (int c = 0; c <= last_cyc; c++) begin
            niv += int'(a_iv[c]);
            nov += int'(a_ov[c]);
        end
        n_checks++;
        if (niv !== 416) $display("FAIL issue_count: got %0d want 416", niv);
        else n_pass++;
        n_checks++;
        if (nov !== 32) $display("FAIL out_valid_count: got %0d want 32", nov);
        else n_pass++;
        n_checks++;
        if (a_bz[0] !== 1'b1 || a_bz[466] !== 1'b1 || a_bz[467] !== 1'b0 || a_dn[466] !== 1'b0 || a_dn[468] !== 1'b0)
            $display("FAIL busy_done_window: got bz0=%0b bz466=%0b bz467=%0b dn466=%0b dn468=%0b want 1/1/0/0/0",
                     a_bz[0], a_bz[466], a_bz[467], a_dn[466], a_dn[468]);
        else n_pass++;
    endtask

    task automatic test_stage_boundaries();
        run(-1, 0, -1, -1);
        for (int s = 0; s < 12; s++) begin
            int errs = 0;
            int base = (s % 2 == 1) ? 32 : 0;
            for (int k = 0; k < 32; k++) begin
                int c = 1 + 36 * s + k;
                if (a_iv[c] !== 1'b1 || a_a0[c] !== 9'(base + k) || a_a1[c] !== 9'(base + k)) errs++;
            end
            for (int g = 0; g < 4; g++) if (a_iv[33 + 36 * s + g] !== 1'b0) errs++;
            n_checks++;
            if (errs != 0) $display("FAIL stage%0d_addresses: got %0d bad cycles want 0", s, errs);
            else n_pass++;
            n_checks++;
            if (a_lt[1 + 36 * s] !== 4'(11 - s) || a_lm[1 + 36 * s] !== 4'(s))
                $display("FAIL stage%0d_log: got m=%0d t=%0d want m=%0d t=%0d", s, a_lm[1 + 36 * s], a_lt[1 + 36 * s], s, 11 - s);
            else n_pass++;
            n_checks++;
            if (a_ph[1 + 36 * s] !== ((s < 6) ? 2'd0 : 2'd1))
                $display("FAIL stage%0d_phase: got %0d want %0d", s, a_ph[1 + 36 * s], (s < 6) ? 0 : 1);
            else n_pass++;
        end
        n_checks++;
        if (a_a0[33] !== 9'd31 || a_lt[33] !== 4'd11) $display("FAIL drain_hold: got a=%0d t=%0d want 31/11", a_a0[33], a_lt[33]);
        else n_pass++;
    endtask

    task automatic test_output_pass();
        int errs = 0;
        run(-1, 0, -1, -1);
        for (int k = 0; k < 32; k++) begin
            int c = 433 + k;
            if (a_iv[c] !== 1'b1 || a_a0[c] !== 9'(32 + k) || a_lt[c] !== 4'd15 || a_lm[c] !== 4'd12 || a_ph[c] !== 2'd2) errs++;
            if (a_ov[c + 2] !== 1'b1) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL output_pass: got %0d bad cycles want 0", errs);
        else n_pass++;
        n_checks++;
        if (a_ov[434] !== 1'b0 || a_ov[467] !== 1'b0 || a_iv[465] !== 1'b0 || a_iv[432] !== 1'b0)
            $display("FAIL output_edges: got ov434=%0b ov467=%0b iv465=%0b iv432=%0b want 0/0/0/0", a_ov[434], a_ov[467], a_iv[465], a_iv[432]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int errs = 0;
        int niv = 0;
        int nov = 0;
        run(443, 5, -1, -1);
        n_checks++;
        if (a_done !== 472) $display("FAIL bp_done_cycle: got %0d want 472", a_done);
        else n_pass++;
        for (int c = 443; c < 448; c++) if (a_iv[c] !== 1'b0 || a_a0[c] !== 9'd42) errs++;
        n_checks++;
        if (errs != 0) $display("FAIL bp_stall_hold: got %0d bad cycles want 0", errs);
        else n_pass++;
        n_checks++;
        if (a_iv[442] !== 1'b1 || a_a0[442] !== 9'd41 || a_iv[448] !== 1'b1 || a_a0[448] !== 9'd42)
            $display("FAIL bp_resume: got a442=%0d a448=%0d want 41/42", a_a0[442], a_a0[448]);
        else n_pass++;
        for (int c = 0; c <= last_cyc; c++) begin
            niv += int'(a_iv[c]);
            nov += int'(a_ov[c]);
        end
        n_checks++;
        if (niv !== 416 || nov !== 32 || a_a0[469] !== 9'd63)
            $display("FAIL bp_counts: got iv=%0d ov=%0d last=%0d want 416/32/63", niv, nov, a_a0[469]);
        else n_pass++;
    endtask

    task automatic test_start_ignored_and_reset();
        int ndn = 0;
        int niv = 0;
        run(-1, 0, 100, 200);
        n_checks++;
        if (a_a0[101] !== 9'd28 || a_a0[110] !== 9'd33 || a_lt[110] !== 4'd8 || a_a0[199] !== 9'd50)
            $display("FAIL start_ignored: got a101=%0d a110=%0d t110=%0d a199=%0d want 28/33/8/50", a_a0[101], a_a0[110], a_lt[110], a_a0[199]);
        else n_pass++;
        n_checks++;
        if (a_iv[200] !== 1'b0 || a_lm[200] !== 4'd0 || a_lt[200] !== 4'd11 || a_a0[200] !== 9'd0 || a_a1[200] !== 9'd0)
            $display("FAIL midrun_reset_fields: got iv=%0b m=%0d t=%0d a=%0d want 0/0/11/0", a_iv[200], a_lm[200], a_lt[200], a_a0[200]);
        else n_pass++;
        n_checks++;
        if (a_ph[200] !== 2'd3 || a_bz[200] !== 1'b0 || a_ov[200] !== 1'b0)
            $display("FAIL midrun_reset_status: got ph=%0d bz=%0b ov=%0b want 3/0/0", a_ph[200], a_bz[200], a_ov[200]);
        else n_pass++;
        for (int c = 0; c <= last_cyc; c++) ndn += int'(a_dn[c]);
        n_checks++;
        if (ndn !== 0) $display("FAIL midrun_no_done: got %0d pulses want 0", ndn);
        else n_pass++;
        run(-1, 0, -1, -1);
        for (int c = 0; c <= last_cyc; c++) niv += int'(a_iv[c]);
        n_checks++;
        if (a_done !== 467 || niv !== 416) $display("FAIL restart_after_reset: got done=%0d iv=%0d want 467/416", a_done, niv);
        else n_pass++;
    endtask

    task automatic test_sweep();
        int niv = 0;
        run(-1, 0, -1, -1);
        n_checks++;
        if (b_done !== 847) $display("FAIL sweep_done_cycle: got %0d want 847", b_done);
        else n_pass++;
        n_checks++;
        if (b_a0[64] !== 9'd63 || b_iv[65] !== 1'b0 || b_iv[66] !== 1'b1 || b_a0[66] !== 9'd64)
            $display("FAIL sweep_banks: got a64=%0d iv65=%0b a66=%0d want 63/0/64", b_a0[64], b_iv[65], b_a0[66]);
        else n_pass++;
        n_checks++;
        if (b_ph[261] !== 2'd0 || b_ph[326] !== 2'd1 || b_lt[326] !== 4'd6)
            $display("FAIL sweep_phase_edge: got ph261=%0d ph326=%0d t326=%0d want 0/1/6", b_ph[261], b_ph[326], b_lt[326]);
        else n_pass++;
        for (int c = 0; c <= last_cyc; c++) niv += int'(b_iv[c]);
        n_checks++;
        if (b_a0[781] !== 9'd64 || b_a0[844] !== 9'd127 || b_lt[781] !== 4'd15 || niv !== 832)
            $display("FAIL sweep_output: got a781=%0d a844=%0d t781=%0d iv=%0d want 64/127/15/832", b_a0[781], b_a0[844], b_lt[781], niv);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stage_boundaries();
        test_output_pass();
        test_backpressure();
        test_start_ignored_and_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
